// File: rtl/proc_context_if.sv
// Control/datapath bundle for proc_context_unit: BIOS control, next-PC input and
// per-context fetch outputs. master = control unit / BIOS side, slave = the unit.
interface proc_context_if #(
   parameter int ADDR_W    = 32,
   parameter int PID_W     = 2,
   parameter int QUANTUM_W = 16
);
   logic                 pc_write;
   logic [ADDR_W-1:0]    prox_pc;
   logic                 ctx_load;
   logic [PID_W-1:0]     load_pid;
   logic [ADDR_W-1:0]    load_pc;
   logic                 ctx_switch;
   logic [PID_W-1:0]     sel_pid;
   logic [QUANTUM_W-1:0] quantum;
   logic                 bios_trap;
   logic                 preempt_ack;
   logic [ADDR_W-1:0]    process_pc;
   logic [ADDR_W-1:0]    write_ra;
   logic [PID_W-1:0]     active_pid;
   logic                 bios_mode;
   logic                 preempt;

   modport master (
      output pc_write, prox_pc, ctx_load, load_pid, load_pc, ctx_switch,
             sel_pid, quantum, bios_trap, preempt_ack,
      input  process_pc, write_ra, active_pid, bios_mode, preempt
   );

   modport slave (
      input  pc_write, prox_pc, ctx_load, load_pid, load_pc, ctx_switch,
             sel_pid, quantum, bios_trap, preempt_ack,
      output process_pc, write_ra, active_pid, bios_mode, preempt
   );
endinterface

// File: rtl/proc_context_unit.sv
// Multi-context PC unit: one BIOS PC plus NPROC user PCs with BIOS-driven switching.
// Optional instruction-count preemption timer enabled by defining PREEMPT_TIMER_EN.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_BIOS    | BIOS context runs; may load user PCs and switch to a pid
//   ST_RUN     | user context active_pid runs; leaves on bios_trap
//   ST_PREEMPT | quantum expired; user PC frozen until preempt_ack
module proc_context_unit #(
   parameter int ADDR_W    = 32,
   parameter int NPROC     = 4,
   parameter int PID_W     = 2,
   parameter int QUANTUM_W = 16
) (
   input logic              clk,
   input logic              rst_n,
   proc_context_if.slave    bus
);

`ifdef PREEMPT_TIMER_EN
   typedef enum logic [1:0] {
      ST_BIOS    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PREEMPT = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_BIOS    = 2'd0,
      ST_RUN     = 2'd1
   } state_t;
`endif

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   bios_pc;
   logic [ADDR_W-1:0]   upc [NPROC];
   logic [PID_W-1:0]    active_pid;
   logic                in_bios;
   logic                in_run;

   assign in_bios = (state == ST_BIOS);
   assign in_run  = (state == ST_RUN);

`ifdef PREEMPT_TIMER_EN
   logic [QUANTUM_W-1:0] cnt;
   logic                 cnt_expire;

   // cnt==0 means unlimited, so only a decrement from 1 expires the slice
   assign cnt_expire = in_run && bus.pc_write && (cnt == QUANTUM_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (in_bios && bus.ctx_switch) begin
         cnt <= bus.quantum;
      end else if (in_run && bus.pc_write && (cnt != '0)) begin
         cnt <= cnt - QUANTUM_W'(1);
      end
   end
`else
   logic unused_timer_inputs;
   assign unused_timer_inputs = ^{bus.quantum, bus.preempt_ack};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_BIOS;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_BIOS: begin
            if (bus.ctx_switch) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (bus.bios_trap) begin
               state_nxt = ST_BIOS;
`ifdef PREEMPT_TIMER_EN
            end else if (cnt_expire) begin
               state_nxt = ST_PREEMPT;
`endif
            end
         end
`ifdef PREEMPT_TIMER_EN
         ST_PREEMPT: begin
            if (bus.preempt_ack) state_nxt = ST_BIOS;
         end
`endif
         default: state_nxt = ST_BIOS;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bios_pc    <= '0;
         active_pid <= '0;
      end else if (in_bios) begin
         if (bus.pc_write)   bios_pc    <= bus.prox_pc;
         if (bus.ctx_switch) active_pid <= bus.sel_pid;
      end
   end

   // BIOS loads and RUN commits are exclusive by state, so one write port suffices
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NPROC; i++) upc[i] <= '0;
      end else if (in_bios && bus.ctx_load) begin
         upc[bus.load_pid] <= bus.load_pc;
      end else if (in_run && bus.pc_write) begin
         upc[active_pid] <= bus.prox_pc;
      end
   end

   assign bus.process_pc = in_bios ? bios_pc : upc[active_pid];
   assign bus.write_ra   = bus.process_pc + ADDR_W'(1);
   assign bus.active_pid = active_pid;
   assign bus.bios_mode  = in_bios;
`ifdef PREEMPT_TIMER_EN
   assign bus.preempt    = (state == ST_PREEMPT);
`else
   assign bus.preempt    = 1'b0;
`endif

endmodule

// File: tb/tb_proc_context_unit.sv
// Directed self-checking bench for proc_context_unit; preemption steps follow
// whichever PREEMPT_TIMER_EN build is compiled.
module tb_proc_context_unit;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   proc_context_if #(.ADDR_W(32), .PID_W(2), .QUANTUM_W(16)) bus ();

   proc_context_unit #(.ADDR_W(32), .NPROC(4), .PID_W(2), .QUANTUM_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.pc_write    = 1'b0;
      bus.ctx_load    = 1'b0;
      bus.ctx_switch  = 1'b0;
      bus.bios_trap   = 1'b0;
      bus.preempt_ack = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle();
      bus.prox_pc  = '0;
      bus.load_pid = '0;
      bus.load_pc  = '0;
      bus.sel_pid  = '0;
      bus.quantum  = '0;
      #12;
      chk("rst_bios_mode", bus.bios_mode, 1);
      chk("rst_preempt", bus.preempt, 0);
      chk("rst_process_pc", bus.process_pc, 0);
      chk("rst_write_ra", bus.write_ra, 1);
      chk("rst_active_pid", bus.active_pid, 0);
      #2 rst_n = 1'b1;
      tick();

      // BIOS pc_write
      bus.pc_write = 1'b1; bus.prox_pc = 32'd5;
      tick(); idle();
      chk("bios_pc_write_mode", bus.bios_mode, 1);
      chk("bios_pc_write_pc", bus.process_pc, 5);
      chk("bios_pc_write_ra", bus.write_ra, 6);

      // load contexts, switch among them
      bus.ctx_load = 1'b1; bus.load_pid = 2'd2; bus.load_pc = 32'h100;
      tick();
      bus.load_pid = 2'd1; bus.load_pc = 32'h200;
      tick(); idle();
      bus.ctx_switch = 1'b1; bus.sel_pid = 2'd2; bus.quantum = 16'd0;
      tick(); idle();
      chk("sw2_mode", bus.bios_mode, 0);
      chk("sw2_pc", bus.process_pc, 32'h100);
      chk("sw2_ra", bus.write_ra, 32'h101);
      chk("sw2_pid", bus.active_pid, 2);
      bus.bios_trap = 1'b1;
      tick(); idle();
      chk("trap_mode", bus.bios_mode, 1);
      chk("trap_bios_pc", bus.process_pc, 5);
      bus.ctx_switch = 1'b1; bus.sel_pid = 2'd1;
      tick(); idle();
      chk("sw1_pc", bus.process_pc, 32'h200);
      bus.bios_trap = 1'b1;
      tick(); idle();
      bus.ctx_switch = 1'b1; bus.sel_pid = 2'd2;
      tick(); idle();
      chk("sw2_again_pc", bus.process_pc, 32'h100);
      bus.bios_trap = 1'b1;
      tick(); idle();
      bus.ctx_switch = 1'b1; bus.sel_pid = 2'd3;
      tick(); idle();
      chk("sw3_untouched_pc", bus.process_pc, 0);
      bus.pc_write = 1'b1; bus.prox_pc = 32'h300;
      tick(); idle();
      chk("run_pc_write", bus.process_pc, 32'h300);
      chk("q0_no_preempt", bus.preempt, 0);
      bus.bios_trap = 1'b1;
      tick(); idle();

`ifdef PREEMPT_TIMER_EN
      bus.ctx_switch = 1'b1; bus.sel_pid = 2'd0; bus.quantum = 16'd3;
      tick(); idle();
      bus.pc_write = 1'b1; bus.prox_pc = 32'h10;
      tick();
      chk("q3_w1_preempt", bus.preempt, 0);
      chk("q3_w1_pc", bus.process_pc, 32'h10);
      bus.prox_pc = 32'h11;
      tick();
      chk("q3_w2_preempt", bus.preempt, 0);
      bus.prox_pc = 32'h12;
      tick();
      chk("q3_w3_preempt", bus.preempt, 1);
      chk("q3_w3_pc", bus.process_pc, 32'h12);
      chk("q3_w3_mode", bus.bios_mode, 0);
      bus.prox_pc = 32'h13;
      tick(); idle();
      chk("q3_w4_frozen_pc", bus.process_pc, 32'h12);
      chk("q3_w4_preempt_held", bus.preempt, 1);
      bus.preempt_ack = 1'b1;
      tick(); idle();
      chk("ack_mode", bus.bios_mode, 1);
      chk("ack_preempt", bus.preempt, 0);
`else
      bus.ctx_switch = 1'b1; bus.sel_pid = 2'd0; bus.quantum = 16'd1;
      tick(); idle();
      bus.pc_write = 1'b1; bus.prox_pc = 32'h10;
      tick();
      chk("noq_w1_preempt", bus.preempt, 0);
      chk("noq_w1_mode", bus.bios_mode, 0);
      chk("noq_w1_pc", bus.process_pc, 32'h10);
      bus.prox_pc = 32'h11;
      tick(); idle();
      chk("noq_w2_pc", bus.process_pc, 32'h11);
      chk("noq_w2_preempt", bus.preempt, 0);
      bus.bios_trap = 1'b1;
      tick(); idle();
`endif

      // pc_write + bios_trap on the would-be expiring instruction
      bus.ctx_switch = 1'b1; bus.sel_pid = 2'd0; bus.quantum = 16'd2;
      tick(); idle();
      bus.pc_write = 1'b1; bus.prox_pc = 32'h20;
      tick();
      bus.prox_pc = 32'h21; bus.bios_trap = 1'b1;
      tick(); idle();
      chk("trap_win_mode", bus.bios_mode, 1);
      chk("trap_win_preempt", bus.preempt, 0);
      chk("trap_win_bios_pc", bus.process_pc, 5);
      bus.quantum = 16'd0;
      bus.ctx_switch = 1'b1; bus.sel_pid = 2'd0;
      tick(); idle();
      chk("trap_win_saved_upc", bus.process_pc, 32'h21);

      // ctx_load / ctx_switch ignored while running
      bus.ctx_load = 1'b1; bus.load_pid = 2'd0; bus.load_pc = 32'hDEAD;
      bus.ctx_switch = 1'b1; bus.sel_pid = 2'd1;
      tick(); idle();
      chk("run_load_ignored", bus.process_pc, 32'h21);
      chk("run_switch_ignored", bus.active_pid, 0);
      chk("run_switch_mode", bus.bios_mode, 0);
      bus.bios_trap = 1'b1;
      tick(); idle();
      bus.ctx_load = 1'b1; bus.load_pid = 2'd1; bus.load_pc = 32'hBEEF;
      bus.ctx_switch = 1'b1; bus.sel_pid = 2'd1;
      tick(); idle();
      chk("load_switch_pc", bus.process_pc, 32'hBEEF);
      chk("load_switch_pid", bus.active_pid, 1);
      bus.bios_trap = 1'b1;
      tick(); idle();

      // write_ra wraps
      bus.pc_write = 1'b1; bus.prox_pc = 32'hFFFF_FFFF;
      tick(); idle();
      chk("ra_wrap", bus.write_ra, 0);

      // async reset while out of BIOS
`ifdef PREEMPT_TIMER_EN
      bus.ctx_switch = 1'b1; bus.sel_pid = 2'd1; bus.quantum = 16'd1;
      tick(); idle();
      bus.pc_write = 1'b1; bus.prox_pc = 32'h44;
      tick(); idle();
      chk("pre_rst_preempt", bus.preempt, 1);
`else
      bus.ctx_switch = 1'b1; bus.sel_pid = 2'd1; bus.quantum = 16'd1;
      tick(); idle();
      chk("pre_rst_run_mode", bus.bios_mode, 0);
`endif
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_preempt", bus.preempt, 0);
      chk("async_rst_mode", bus.bios_mode, 1);
      chk("async_rst_pc", bus.process_pc, 0);
      chk("async_rst_pid", bus.active_pid, 0);
      #2 rst_n = 1'b1;
      tick();
      bus.quantum = 16'd0;
      bus.ctx_switch = 1'b1; bus.sel_pid = 2'd1;
      tick(); idle();
      chk("post_rst_upc1_cleared", bus.process_pc, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
